// File: rtl/led_sequencer.sv
// led_sequencer: drives a bank of LEDs with one of four patterns. The pattern
// advances once every EDGES_PER_STEP edges of a slow external tick.
//
// Ports:
//   CLK        in   system clock, rising-edge logic
//   RST_N      in   asynchronous active-low reset
//   tick_in    in   slow square wave; every edge (rise or fall) is one tick event
//   enable     in   1 = advance on ticks, 0 = freeze
//   mode       in   00 rotate, 01 bounce, 10 binary count, 11 blink
//   leds       out  registered LED pattern (NUM_LEDS bits)
//   step_pulse out  one-cycle pulse on each pattern advance
//   wrap       out  one-cycle pulse when the pattern returns to its start value
module led_sequencer #(
  parameter int NUM_LEDS       = 5,
  parameter int EDGES_PER_STEP = 2
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                tick_in,
  input  logic                enable,
  input  logic [1:0]          mode,
  output logic [NUM_LEDS-1:0] leds,
  output logic                step_pulse,
  output logic                wrap
);

  localparam int PW = (EDGES_PER_STEP > 1) ? $clog2(EDGES_PER_STEP) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(EDGES_PER_STEP - 1);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Start value of each pattern: one hot bit at bit0 for rotate/bounce,
  // all zero for binary and blink.
  function automatic logic [NUM_LEDS-1:0] init_pattern(input logic [1:0] m);
    logic [NUM_LEDS-1:0] p;
    case (m)
      2'b00, 2'b01: p = NUM_LEDS'(1);
      default:      p = '0;
    endcase
    return p;
  endfunction

  state_t              state, state_n;
  logic [1:0]          init_cnt, init_cnt_n;
  logic                s1, s2, s3;
  logic [PW-1:0]       pre, pre_n;
  logic                dir, dir_n;       // bounce direction, 1 = up
  logic [1:0]          mode_q, mode_q_n;
  logic [NUM_LEDS-1:0] leds_n;
  logic                step_n, wrap_n;
  logic                tick_evt;
  logic [NUM_LEDS-1:0] adv;
  logic                dir_adv;

  // Either edge of the synchronised tick is one event.
  assign tick_evt = s2 ^ s3;

  // Tick synchroniser and edge-history flop.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= tick_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Pattern value one step ahead of the current one, for the latched mode.
  always_comb begin
    adv     = leds;
    dir_adv = dir;
    case (mode_q)
      2'b00: adv = {leds[NUM_LEDS-2:0], leds[NUM_LEDS-1]};
      2'b01: begin
        // Direction flips on reaching an end so no end bit is shown twice.
        if (dir) begin
          adv     = leds << 1;
          dir_adv = ~adv[NUM_LEDS-1];
        end else begin
          adv     = leds >> 1;
          dir_adv = adv[0];
        end
      end
      2'b10: adv = leds + NUM_LEDS'(1);
      2'b11: adv = (leds == '0) ? '1 : '0;
      default: adv = leds;
    endcase
  end

  // Next-state and next-output logic; mode change beats tick advance beats hold.
  always_comb begin
    state_n    = state;
    init_cnt_n = init_cnt;
    pre_n      = pre;
    dir_n      = dir;
    mode_q_n   = mode_q;
    leds_n     = leds;
    step_n     = 1'b0;
    wrap_n     = 1'b0;
    case (state)
      INIT: begin
        // Three cycles of settling; tick events are dropped meanwhile.
        if (init_cnt == 2'd2) begin
          state_n    = RUN;
          init_cnt_n = 2'd0;
          leds_n     = init_pattern(mode);
          mode_q_n   = mode;
          pre_n      = '0;
          dir_n      = 1'b1;
        end else begin
          init_cnt_n = init_cnt + 2'd1;
        end
      end
      RUN: begin
        if (mode != mode_q) begin
          leds_n   = init_pattern(mode);
          mode_q_n = mode;
          pre_n    = '0;
          dir_n    = 1'b1;
        end else if (enable && tick_evt) begin
          if (pre == PRE_LAST) begin
            leds_n = adv;
            dir_n  = dir_adv;
            pre_n  = '0;
            step_n = 1'b1;
            wrap_n = (adv == init_pattern(mode_q));
          end else begin
            pre_n = pre + PW'(1);
          end
        end else begin
          pre_n = pre;
        end
      end
      default: state_n = INIT;
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= INIT;
      init_cnt   <= 2'd0;
      pre        <= '0;
      dir        <= 1'b1;
      mode_q     <= 2'b00;
      leds       <= '0;
      step_pulse <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      state      <= state_n;
      init_cnt   <= init_cnt_n;
      pre        <= pre_n;
      dir        <= dir_n;
      mode_q     <= mode_q_n;
      leds       <= leds_n;
      step_pulse <= step_n;
      wrap       <= wrap_n;
    end
  end

endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer (defaults NUM_LEDS=5, EDGES_PER_STEP=2).
// The reference model tracks "steps since the pattern was loaded" and derives
// the LED value from that count arithmetically.
module tb_led_sequencer;

  logic       CLK;
  logic       RST_N;
  logic       tick_in;
  logic       enable;
  logic [1:0] mode;
  logic [4:0] leds;
  logic       step_pulse;
  logic       wrap;

  led_sequencer dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .tick_in   (tick_in),
    .enable    (enable),
    .mode      (mode),
    .leds      (leds),
    .step_pulse(step_pulse),
    .wrap      (wrap)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Stimulus state
  logic       tin;
  logic       en_v;
  logic [1:0] md_v;

  // Reference model state
  int         n_edge;
  logic       h [4];
  int         k;
  logic [1:0] mm;
  int         pre_m;
  logic [4:0] exp_leds;
  logic       exp_step;
  logic       exp_wrap;

  function automatic int period(input logic [1:0] m);
    case (m)
      2'b00:   return 5;
      2'b01:   return 8;
      2'b10:   return 32;
      default: return 2;
    endcase
  endfunction

  function automatic logic [4:0] pattern(input logic [1:0] m, input int steps);
    int p;
    int idx;
    logic [4:0] r;
    case (m)
      2'b00: begin
        r = 5'b00001 << (steps % 5);
      end
      2'b01: begin
        p   = steps % 8;
        idx = (p < 5) ? p : 8 - p;
        r   = 5'b00001 << idx;
      end
      2'b10: r = 5'(steps % 32);
      default: r = ((steps % 2) == 1) ? 5'b11111 : 5'b00000;
    endcase
    return r;
  endfunction

  task automatic model_reset();
    n_edge = 0;
    for (int i = 0; i < 4; i++) h[i] = 1'b0;
    k        = 0;
    mm       = 2'b00;
    pre_m    = 0;
    exp_leds = 5'b00000;
    exp_step = 1'b0;
    exp_wrap = 1'b0;
  endtask

  // One rising edge of the model with the inputs present at that edge.
  task automatic model_edge(input logic ti, input logic en, input logic [1:0] md);
    logic ev;
    h[3] = h[2];
    h[2] = h[1];
    h[1] = h[0];
    h[0] = ti;
    ev = (h[2] != h[3]);   // input change sampled two edges ago
    n_edge++;
    exp_step = 1'b0;
    exp_wrap = 1'b0;
    if (n_edge == 3) begin
      mm = md; k = 0; pre_m = 0;
    end else if (n_edge > 3) begin
      if (md != mm) begin
        mm = md; k = 0; pre_m = 0;
      end else if (en && ev) begin
        pre_m++;
        if (pre_m == 2) begin
          pre_m    = 0;
          k++;
          exp_step = 1'b1;
          exp_wrap = ((k % period(mm)) == 0);
        end
      end
    end
    exp_leds = (n_edge < 3) ? 5'b00000 : pattern(mm, k);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive inputs, take one clock edge, compare all outputs with the model.
  task automatic step();
    tick_in = tin;
    enable  = en_v;
    mode    = md_v;
    @(posedge CLK);
    model_edge(tin, en_v, md_v);
    #1;
    chk("leds", {11'd0, leds}, {11'd0, exp_leds});
    chk("step_pulse", {15'd0, step_pulse}, {15'd0, exp_step});
    chk("wrap", {15'd0, wrap}, {15'd0, exp_wrap});
  endtask

  task automatic edge_and_step();
    tin = ~tin;
    step();
  endtask

  task automatic flush(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Reset asserted mid-cycle; outputs must clear before the next clock edge.
  task automatic mid_reset(input logic tin_at_release);
    #3;
    RST_N = 1'b0;
    #1;
    chk("async_rst_leds", {11'd0, leds}, 16'd0);
    chk("async_rst_step", {15'd0, step_pulse}, 16'd0);
    chk("async_rst_wrap", {15'd0, wrap}, 16'd0);
    model_reset();
    tin = 1'b0;
    tick_in = 1'b0;
    @(posedge CLK);
    #2;
    tin     = tin_at_release;
    tick_in = tin;
    RST_N   = 1'b1;
  endtask

  initial begin
    RST_N   = 1'b0;
    tin     = 1'b0;
    en_v    = 1'b1;
    md_v    = 2'b00;
    tick_in = 1'b0;
    enable  = 1'b1;
    mode    = 2'b00;
    model_reset();
    #12;
    chk("reset_leds", {11'd0, leds}, 16'd0);
    chk("reset_step", {15'd0, step_pulse}, 16'd0);
    chk("reset_wrap", {15'd0, wrap}, 16'd0);
    RST_N = 1'b1;

    // Rotate: three INIT cycles, then 00001; 2 edges -> 00010; 10 edges -> 00001.
    flush(2);
    chk("init_hold", {11'd0, leds}, 16'd0);
    step();
    chk("rot_init", {11'd0, leds}, 16'h0001);
    edge_and_step();
    edge_and_step();
    flush(2);
    chk("rot_2edges", {11'd0, leds}, 16'h0002);
    for (int i = 0; i < 8; i++) begin
      edge_and_step();
      step();
    end
    flush(1);
    chk("rot_10edges", {11'd0, leds}, 16'h0001);

    // Bounce through a full period.
    md_v = 2'b01;
    step();
    for (int i = 0; i < 16; i++) begin
      edge_and_step();
      step();
    end
    flush(2);
    chk("bounce_period", {11'd0, leds}, 16'h0001);

    // Binary: 62 edges -> 11111, 2 more -> 00000 with wrap.
    md_v = 2'b10;
    step();
    for (int i = 0; i < 62; i++) edge_and_step();
    flush(2);
    chk("bin_ones", {11'd0, leds}, 16'h001f);
    edge_and_step();
    edge_and_step();
    flush(2);
    chk("bin_wrap", {11'd0, leds}, 16'h0000);

    // Rotate to 00100, freeze with enable low, then resume.
    md_v = 2'b00;
    step();
    for (int i = 0; i < 4; i++) edge_and_step();
    flush(2);
    chk("freeze_start", {11'd0, leds}, 16'h0004);
    edge_and_step();
    flush(2);
    en_v = 1'b0;
    for (int i = 0; i < 6; i++) edge_and_step();
    flush(2);
    chk("freeze_hold", {11'd0, leds}, 16'h0004);
    en_v = 1'b1;
    edge_and_step();
    flush(2);
    chk("freeze_resume", {11'd0, leds}, 16'h0008);

    // Mode change coincident with a tick event.
    md_v = 2'b11;
    step();
    md_v = 2'b00;
    step();
    for (int i = 0; i < 4; i++) edge_and_step();
    flush(2);
    chk("mc_start", {11'd0, leds}, 16'h0004);
    edge_and_step();
    step();
    md_v = 2'b10;
    step();
    chk("mc_leds", {11'd0, leds}, 16'h0000);
    chk("mc_no_step", {15'd0, step_pulse}, 16'd0);
    edge_and_step();
    edge_and_step();
    flush(2);
    chk("mc_after", {11'd0, leds}, 16'h0001);

    // Mid-run reset with tick_in high at release.
    edge_and_step();
    md_v = 2'b00;
    mid_reset(1'b1);
    flush(3);
    chk("rst_restart", {11'd0, leds}, 16'h0001);
    flush(3);
    chk("rst_no_spurious", {11'd0, leds}, 16'h0001);

    // Randomised run against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(1, 0) == 1) tin = ~tin;
      en_v = ($urandom_range(7, 0) != 0);
      if ($urandom_range(63, 0) == 0) md_v = 2'($urandom_range(3, 0));
      if ($urandom_range(499, 0) == 0) begin
        mid_reset(1'($urandom_range(1, 0)));
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
